// File: rtl/rd_port_sched_if.sv
// ---------------------------------------------------------------------------
// rd_port_sched_if
//   Bundle of the read-port scheduling signals between the consumers / FIFO
//   flag logic and the read-port scheduler.
//
//   Signals:
//     rd_req    [N_REQ]         per-requester read request (level)
//     rd_empty                  FIFO empty flag, already in rd_clk domain
//     rd_en                     read enable to the read address generator
//     rd_gnt    [N_REQ]         one-hot grant, held for the whole burst
//     rd_ack    [N_REQ]         one-hot pulse, read data belongs to requester
//     rd_busy                   scheduler is in BURST or RELEASE
//     rd_count  [ADDR_WIDTH+1]  reads issued since reset (wrapping)
//
//   Modports:
//     slave   scheduler side (drives rd_en/rd_gnt/rd_ack/rd_busy/rd_count)
//     master  consumer / flag side (drives rd_req/rd_empty)
// ---------------------------------------------------------------------------
interface rd_port_sched_if #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned ADDR_WIDTH = 4
);

   logic [N_REQ-1:0]    rd_req;
   logic                rd_empty;
   logic                rd_en;
   logic [N_REQ-1:0]    rd_gnt;
   logic [N_REQ-1:0]    rd_ack;
   logic                rd_busy;
   logic [ADDR_WIDTH:0] rd_count;

   modport slave (
      input  rd_req,
      input  rd_empty,
      output rd_en,
      output rd_gnt,
      output rd_ack,
      output rd_busy,
      output rd_count
   );

   modport master (
      output rd_req,
      output rd_empty,
      input  rd_en,
      input  rd_gnt,
      input  rd_ack,
      input  rd_busy,
      input  rd_count
   );

endinterface

// File: rtl/rd_port_sched.sv
// ---------------------------------------------------------------------------
// rd_port_sched
//   Read-side scheduler for the asynchronous FIFO. Shares the single FIFO
//   read port between N_REQ consumers in the rd_clk domain using round-robin
//   arbitration with bursts of at most BURST_MAX reads. rd_en is gated with
//   the empty flag so the FIFO can never underflow; rd_ack marks the cycle in
//   which the FIFO's registered read data belongs to each requester.
//
//   Ports:
//     rd_clk   in   read-domain clock, rising edge
//     rst_rd   in   synchronous active-high reset
//     port     rd_port_sched_if.slave
//                 rd_req   in   per-requester request (level)
//                 rd_empty in   FIFO empty flag
//                 rd_en    out  read enable to the read address generator
//                 rd_gnt   out  one-hot grant, registered, held for the burst
//                 rd_ack   out  one-hot data-valid pulse, one cycle after rd_en
//                 rd_busy  out  high in BURST or RELEASE
//                 rd_count out  reads issued since reset, modulo 2^(ADDR_WIDTH+1)
// ---------------------------------------------------------------------------
module rd_port_sched #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned BURST_MAX  = 4,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic          rd_clk,
   input  logic          rst_rd,
   rd_port_sched_if.slave port
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BURST   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;

   logic [IDX_W-1:0]    owner;
   logic [IDX_W-1:0]    last_owner;
   logic [IDX_W-1:0]    pick;
   logic                pick_vld;
   logic [3:0]          beat_cnt;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    ack;
   logic [ADDR_WIDTH:0] count;

   logic                owner_req;
   logic                last_beat;
   logic                en;
   logic                load;
   logic                rel;

   // Round-robin pick: first set request scanning upward from last_owner+1,
   // wrapping modulo N_REQ, so last_owner itself is checked last.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = 32'(last_owner) + i;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!pick_vld && port.rd_req[IDX_W'(idx)]) begin
            pick     = IDX_W'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   // Only the owner's request is looked at while a burst is running.
   assign owner_req = port.rd_req[owner];
   assign last_beat = (beat_cnt == 4'(BURST_MAX - 1));

   // rd_en also drops combinationally during reset so the address generator
   // pointer and rd_count stay in step when both are reset together.
   assign en = (state == BURST) && owner_req && !port.rd_empty && !rst_rd;

   // Next-state / control decode
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      rel      = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nx = BURST;
               load     = 1'b1;
            end
         end
         BURST: begin
            // A dropped request wins over an empty stall; an empty stall
            // alone holds BURST indefinitely.
            if (!owner_req) begin
               state_nx = RELEASE;
            end else if (en && last_beat) begin
               state_nx = RELEASE;
            end
         end
         RELEASE: begin
            state_nx = IDLE;
            rel      = 1'b1;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rst_rd) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Grant / beat / count / ack registers
   always_ff @(posedge rd_clk) begin
      if (rst_rd) begin
         gnt        <= '0;
         ack        <= '0;
         count      <= '0;
         beat_cnt   <= '0;
         owner      <= '0;
         last_owner <= IDX_W'(N_REQ - 1);
      end else begin
         ack <= gnt & {N_REQ{en}};
         if (en) begin
            count    <= count + {{ADDR_WIDTH{1'b0}}, 1'b1};
            beat_cnt <= beat_cnt + 4'd1;
         end
         if (load) begin
            gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            owner    <= pick;
            beat_cnt <= '0;
         end
         if (rel) begin
            gnt        <= '0;
            last_owner <= owner;
         end
      end
   end

   assign port.rd_en    = en;
   assign port.rd_gnt   = gnt;
   assign port.rd_ack   = ack;
   assign port.rd_busy  = (state == BURST) || (state == RELEASE);
   assign port.rd_count = count;

endmodule
